// File: rtl/alu_arbiter_if.sv
// Requester/consumer bundle for alu_arbiter: per-requester operation requests
// and the single shared response channel with status.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ*2-1:0]          req_op;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [IDW-1:0]                rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_out;
  logic                          rsp_c;
  logic                          rsp_n;
  logic                          rsp_v;
  logic                          rsp_z;
  logic                          rsp_err;
  logic                          busy;
  logic [15:0]                   op_count;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_out,
    input  rsp_c, rsp_n, rsp_v, rsp_z, rsp_err, busy, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_out,
    output rsp_c, rsp_n, rsp_v, rsp_z, rsp_err, busy, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one saturating signed ALU among NUM_REQ requesters;
// one operation in flight: accept (IDLE) -> compute (EXEC) -> hold result (RESP).
module ALU_Integer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0] A,
  input  logic signed [DATA_WIDTH-1:0] B,
  input  logic        [1:0]            Op,
  output logic signed [DATA_WIDTH-1:0] Out,
  output logic                         C,
  output logic                         N,
  output logic                         V,
  output logic                         Z
);
  localparam int WW = 2 * DATA_WIDTH;
  localparam logic signed [WW-1:0] SMAX = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] SMIN = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] OMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [WW-1:0]   a_w;
  logic signed [WW-1:0]   b_w;
  logic signed [WW-1:0]   wide;
  logic [DATA_WIDTH:0]    usum;

  assign a_w  = WW'(A);
  assign b_w  = WW'(B);
  assign usum = {1'b0, A} + {1'b0, B};

  // Full-precision result then clamp; C is unsigned carry (add) / borrow (sub), 0 for mul.
  always_comb begin
    wide = '0;
    C    = 1'b0;
    case (Op)
      2'b00: begin
        wide = a_w + b_w;
        C    = usum[DATA_WIDTH];
      end
      2'b01: begin
        wide = a_w - b_w;
        C    = ($unsigned(A) < $unsigned(B));
      end
      2'b10: wide = a_w * b_w;
      default: wide = '0;
    endcase
    V   = 1'b0;
    Out = wide[DATA_WIDTH-1:0];
    if (wide > SMAX) begin
      Out = OMAX;
      V   = 1'b1;
    end else if (wide < SMIN) begin
      Out = OMIN;
      V   = 1'b1;
    end
    N = Out[DATA_WIDTH-1];
    Z = (Out == '0);
  end
endmodule

module alu_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                  state_q, state_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]              op_q, op_d;
  logic [IDW-1:0]          id_q, id_d;
  logic [DATA_WIDTH-1:0]   rsp_out_q, rsp_out_d;
  logic                    rsp_c_q, rsp_c_d, rsp_n_q, rsp_n_d;
  logic                    rsp_v_q, rsp_v_d, rsp_z_q, rsp_z_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [IDW-1:0]          rsp_id_q, rsp_id_d;
  logic [15:0]             op_count_q, op_count_d;

  logic [IDW-1:0]          scan_idx;
  logic [IDW-1:0]          gnt_idx;
  logic                    gnt_found;
  logic [NUM_REQ-1:0]      ready;
  logic [1:0]              alu_op;
  logic [DATA_WIDTH-1:0]   alu_out;
  logic                    alu_c, alu_n, alu_v, alu_z;

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && bus.req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // The reserved opcode never reaches the ALU; its result is forced in EXEC.
  assign alu_op = (op_q == 2'b11) ? 2'b00 : op_q;

  ALU_Integer #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .A   (a_q),
    .B   (b_q),
    .Op  (alu_op),
    .Out (alu_out),
    .C   (alu_c),
    .N   (alu_n),
    .V   (alu_v),
    .Z   (alu_z)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    id_d       = id_q;
    rsp_out_d  = rsp_out_q;
    rsp_c_d    = rsp_c_q;
    rsp_n_d    = rsp_n_q;
    rsp_v_d    = rsp_v_q;
    rsp_z_d    = rsp_z_q;
    rsp_err_d  = rsp_err_q;
    rsp_id_d   = rsp_id_q;
    op_count_d = op_count_q;
    ready      = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          ready[gnt_idx] = 1'b1;
          a_d      = bus.req_a[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
          b_d      = bus.req_b[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
          op_d     = bus.req_op[gnt_idx*2 +: 2];
          id_d     = gnt_idx;
          rr_ptr_d = IDW'((32'(gnt_idx) + 32'd1) % NUM_REQ);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_id_d = id_q;
        if (op_q == 2'b11) begin
          rsp_out_d = '0;
          rsp_c_d   = 1'b0;
          rsp_n_d   = 1'b0;
          rsp_v_d   = 1'b0;
          rsp_z_d   = 1'b0;
          rsp_err_d = 1'b1;
        end else begin
          rsp_out_d = alu_out;
          rsp_c_d   = alu_c;
          rsp_n_d   = alu_n;
          rsp_v_d   = alu_v;
          rsp_z_d   = alu_z;
          rsp_err_d = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= '0;
      rsp_out_q  <= '0;
      rsp_c_q    <= 1'b0;
      rsp_n_q    <= 1'b0;
      rsp_v_q    <= 1'b0;
      rsp_z_q    <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_id_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      id_q       <= id_d;
      rsp_out_q  <= rsp_out_d;
      rsp_c_q    <= rsp_c_d;
      rsp_n_q    <= rsp_n_d;
      rsp_v_q    <= rsp_v_d;
      rsp_z_q    <= rsp_z_d;
      rsp_err_q  <= rsp_err_d;
      rsp_id_q   <= rsp_id_d;
      op_count_q <= op_count_d;
    end
  end

  // State already reads IDLE during reset, so the grant must be masked explicitly.
  assign bus.req_ready = ready & {NUM_REQ{rst_n}};
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_n     = rsp_n_q;
  assign bus.rsp_v     = rsp_v_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level arbitration/arithmetic model.
module tb_alu_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;

  typedef struct packed {
    logic [DW-1:0] out;
    logic c, n, v, z, err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();
  alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [NR-1:0] drv_valid;
  logic [DW-1:0] drv_a [NR];
  logic [DW-1:0] drv_b [NR];
  logic [1:0]    drv_op [NR];
  logic          drv_rsp_ready;

  bit          m_pending;
  int          m_age;
  int          m_rr;
  logic [1:0]  m_id;
  res_t        m_res;
  logic [15:0] m_count;

  int   cyc = 0;
  int   last_grant, obs_grant, acc_cyc, first_rv_cyc, hs_count = 0;
  logic prev_rv;
  res_t cap;
  logic [1:0] cap_id;

  function automatic res_t model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] op);
    res_t r;
    int sa = $signed(a);
    int sb = $signed(b);
    int mx = 2 ** (DW - 1) - 1;
    int mn = -(2 ** (DW - 1));
    int x  = 0;
    r = '0;
    if (op == 2'b11) begin
      r.err = 1'b1;
      return r;
    end
    case (op)
      2'b00: begin x = sa + sb; r.c = ((int'(a) + int'(b)) > 2 ** DW - 1); end
      2'b01: begin x = sa - sb; r.c = (a < b); end
      default: x = sa * sb;
    endcase
    if (x > mx) begin
      x = mx; r.v = 1'b1;
    end else if (x < mn) begin
      x = mn; r.v = 1'b1;
    end
    r.out = DW'(x);
    r.n   = r.out[DW-1];
    r.z   = (r.out == '0);
    return r;
  endfunction

  task automatic drive_bus();
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*DW +: DW] = drv_a[i];
      bus.req_b[i*DW +: DW] = drv_b[i];
      bus.req_op[i*2 +: 2]  = drv_op[i];
    end
    bus.req_valid = drv_valid;
    bus.rsp_ready = drv_rsp_ready;
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_age     = 0;
    m_rr      = 0;
    m_count   = '0;
    prev_rv   = 1'b0;
  endtask

  // One clock: drive, compare against the model, then advance the model. Entered at negedge.
  task automatic step();
    int g;
    int idx;
    bit exp_rv;
    logic [NR-1:0] er;
    res_t act;
    drive_bus();
    #1;
    g  = -1;
    er = '0;
    if (!m_pending)
      for (int k = 0; k < NR; k++) begin
        idx = (m_rr + k) % NR;
        if (g < 0 && drv_valid[idx]) g = idx;
      end
    if (g >= 0) er[g] = 1'b1;
    exp_rv = m_pending && (m_age >= 2);
    total++;
    if (bus.req_ready !== er) begin
      bad++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, er);
    end
    total++;
    if (bus.rsp_valid !== exp_rv) begin
      bad++; $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_rv);
    end
    total++;
    if (bus.busy !== m_pending) begin
      bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, m_pending);
    end
    total++;
    if (bus.op_count !== m_count) begin
      bad++; $display("FAIL op_count cyc=%0d got=%0d exp=%0d", cyc, bus.op_count, m_count);
    end
    act = {bus.rsp_out, bus.rsp_c, bus.rsp_n, bus.rsp_v, bus.rsp_z, bus.rsp_err};
    if (exp_rv) begin
      total++;
      if (act !== m_res || bus.rsp_id !== m_id) begin
        bad++;
        $display("FAIL rsp_data cyc=%0d got out/cnvz/err=%h id=%0d exp=%h id=%0d",
                 cyc, act, bus.rsp_id, m_res, m_id);
      end
    end
    obs_grant = -1;
    for (int i = 0; i < NR; i++)
      if (bus.req_ready[i] === 1'b1 && drv_valid[i]) obs_grant = i;
    if (bus.rsp_valid === 1'b1 && prev_rv !== 1'b1) first_rv_cyc = cyc;
    prev_rv    = bus.rsp_valid;
    last_grant = g;
    if (g >= 0) begin
      m_pending = 1'b1;
      m_age     = 1;
      m_res     = model(drv_a[g], drv_b[g], drv_op[g]);
      m_id      = 2'(g);
      m_rr      = (g + 1) % NR;
      acc_cyc   = cyc;
    end else if (m_pending) begin
      if (m_age >= 2 && drv_rsp_ready) begin
        m_pending = 1'b0;
        m_count   = m_count + 16'd1;
        cap       = act;
        cap_id    = bus.rsp_id;
        hs_count++;
      end else if (m_age < 2) begin
        m_age++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic issue(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] op);
    int h0;
    bit got = 1'b0;
    drv_valid[id] = 1'b1;
    drv_a[id]     = a;
    drv_b[id]     = b;
    drv_op[id]    = op;
    for (int t = 0; t < 20 && !got; t++) begin
      step();
      if (obs_grant == id) got = 1'b1;
    end
    drv_valid[id] = 1'b0;
    total++;
    if (!got) begin bad++; $display("FAIL issue_grant id=%0d got=none exp=grant", id); end
    h0 = hs_count;
    for (int t = 0; t < 30 && hs_count == h0; t++) step();
    total++;
    if (hs_count == h0) begin bad++; $display("FAIL issue_rsp id=%0d got=timeout exp=handshake", id); end
  endtask

  task automatic drain();
    drv_valid     = '0;
    drv_rsp_ready = 1'b1;
    for (int t = 0; t < 10 && m_pending; t++) step();
    step();
    total++;
    if (m_pending) begin bad++; $display("FAIL drain got=pending exp=idle"); end
  endtask

  task automatic do_reset();
    drv_valid     = '0;
    drv_rsp_ready = 1'b1;
    drive_bus();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) begin
      drv_a[i] = DW'($urandom); drv_b[i] = DW'($urandom); drv_op[i] = 2'(i);
    end
    drv_valid     = '1;
    drv_rsp_ready = 1'b1;
    drive_bus();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.req_ready !== '0)    begin bad++; $display("FAIL rst_req_ready got=%b exp=0", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0)  begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.rsp_out !== '0)      begin bad++; $display("FAIL rst_rsp_out got=%h exp=0", bus.rsp_out); end
    total++; if (bus.rsp_id !== '0)       begin bad++; $display("FAIL rst_rsp_id got=%0d exp=0", bus.rsp_id); end
    total++;
    if ({bus.rsp_c, bus.rsp_n, bus.rsp_v, bus.rsp_z, bus.rsp_err} !== 5'b0) begin
      bad++; $display("FAIL rst_flags got=%b exp=00000", {bus.rsp_c, bus.rsp_n, bus.rsp_v, bus.rsp_z, bus.rsp_err});
    end
    total++; if (bus.op_count !== 16'd0)  begin bad++; $display("FAIL rst_op_count got=%0d exp=0", bus.op_count); end
    @(negedge clk);
    drv_valid = '0;
    drive_bus();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_add();
    drv_rsp_ready = 1'b1;
    issue(0, 8'h01, 8'h01, 2'b00);
    total++; if (cap.out !== 8'h02) begin bad++; $display("FAIL add_out got=%h exp=02", cap.out); end
    total++; if ({cap.n, cap.v, cap.z} !== 3'b000) begin bad++; $display("FAIL add_nvz got=%b exp=000", {cap.n, cap.v, cap.z}); end
    total++; if (cap_id !== 2'd0) begin bad++; $display("FAIL add_id got=%0d exp=0", cap_id); end
    total++; if (bus.op_count !== 16'd1) begin bad++; $display("FAIL add_count got=%0d exp=1", bus.op_count); end
    total++;
    if (first_rv_cyc - acc_cyc != 2) begin
      bad++; $display("FAIL add_latency got=%0d exp=2", first_rv_cyc - acc_cyc);
    end
  endtask

  task automatic test_saturation();
    drv_rsp_ready = 1'b1;
    issue(1, 8'h7F, 8'h01, 2'b00);
    total++; if (cap.out !== 8'h7F || cap.v !== 1'b1 || cap.n !== 1'b0) begin
      bad++; $display("FAIL sat_add got=%h v=%b n=%b exp=7f v=1 n=0", cap.out, cap.v, cap.n);
    end
    issue(1, 8'hC0, 8'h0A, 2'b10);
    total++; if (cap.out !== 8'h80 || cap.v !== 1'b1 || cap.n !== 1'b1) begin
      bad++; $display("FAIL sat_mul got=%h v=%b n=%b exp=80 v=1 n=1", cap.out, cap.v, cap.n);
    end
    issue(1, 8'hFF, 8'hFF, 2'b01);
    total++; if (cap.out !== 8'h00 || cap.z !== 1'b1 || cap.err !== 1'b0) begin
      bad++; $display("FAIL sub_zero got=%h z=%b err=%b exp=00 z=1 err=0", cap.out, cap.z, cap.err);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] c0 = m_count;
    drv_rsp_ready = 1'b1;
    issue(2, 8'h05, 8'h03, 2'b11);
    total++; if (cap.out !== 8'h00) begin bad++; $display("FAIL ill_out got=%h exp=00", cap.out); end
    total++; if ({cap.c, cap.n, cap.v, cap.z, cap.err} !== 5'b00001) begin
      bad++; $display("FAIL ill_flags got=%b exp=00001", {cap.c, cap.n, cap.v, cap.z, cap.err});
    end
    total++; if (cap_id !== 2'd2) begin bad++; $display("FAIL ill_id got=%0d exp=2", cap_id); end
    total++; if (bus.op_count !== c0 + 16'd1) begin bad++; $display("FAIL ill_count got=%0d exp=%0d", bus.op_count, c0 + 16'd1); end
  endtask

  task automatic test_backpressure();
    bit got = 1'b0;
    drv_rsp_ready = 1'b0;
    drv_valid[3] = 1'b1; drv_a[3] = 8'h20; drv_b[3] = 8'h30; drv_op[3] = 2'b00;
    for (int t = 0; t < 10 && !got; t++) begin
      step();
      if (obs_grant == 3) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL bp_grant got=none exp=3"); end
    drv_valid[3] = 1'b0;
    drv_valid[1] = 1'b1; drv_a[1] = 8'h11; drv_b[1] = 8'h22; drv_op[1] = 2'b01;
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.busy !== 1'b1 || bus.req_ready !== '0 ||
          bus.rsp_out !== 8'h50 || bus.rsp_id !== 2'd3) begin
        bad++;
        $display("FAIL bp_hold k=%0d got v=%b busy=%b rdy=%b out=%h id=%0d exp v=1 busy=1 rdy=0 out=50 id=3",
                 k, bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_out, bus.rsp_id);
      end
      step();
    end
    drv_rsp_ready = 1'b1;
    step();
    step();
    total++; if (obs_grant !== 1) begin bad++; $display("FAIL bp_next_grant got=%0d exp=1", obs_grant); end
    drain();
  endtask

  task automatic test_round_robin();
    int gq[$];
    int cq[$];
    int exp_o[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < NR; i++) begin
      drv_a[i] = DW'($urandom); drv_b[i] = DW'($urandom); drv_op[i] = 2'($urandom_range(0, 3));
    end
    drv_valid     = '1;
    drv_rsp_ready = 1'b1;
    for (int t = 0; t < 18; t++) begin
      step();
      if (obs_grant >= 0) begin gq.push_back(obs_grant); cq.push_back(cyc - 1); end
    end
    total++;
    if (gq.size() < 6) begin
      bad++; $display("FAIL rr_count got=%0d exp>=6", gq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (gq[i] != exp_o[i]) begin bad++; $display("FAIL rr_order i=%0d got=%0d exp=%0d", i, gq[i], exp_o[i]); end
      end
      for (int i = 1; i < 6; i++) begin
        total++;
        if (cq[i] - cq[i-1] != 3) begin bad++; $display("FAIL rr_spacing i=%0d got=%0d exp=3", i, cq[i] - cq[i-1]); end
      end
    end
    drain();
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NR; i++)
        if (!drv_valid[i] && $urandom_range(0, 2) == 0) begin
          drv_valid[i] = 1'b1;
          drv_a[i]     = DW'($urandom);
          drv_b[i]     = DW'($urandom);
          drv_op[i]    = 2'($urandom_range(0, 3));
        end
      drv_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      if (last_grant >= 0) drv_valid[last_grant] = 1'b0;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    drv_rsp_ready = 1'b0;
    drv_valid[2] = 1'b1; drv_a[2] = 8'h05; drv_b[2] = 8'h03; drv_op[2] = 2'b00;
    for (int t = 0; t < 10 && !got; t++) begin
      step();
      if (obs_grant == 2) got = 1'b1;
    end
    drv_valid[2] = 1'b0;
    step();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL rm_in_resp got=%b exp=1", bus.rsp_valid); end
    drv_valid = 4'b1001;
    drive_bus();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== '0 ||
        bus.rsp_out !== '0 || bus.rsp_id !== '0 || bus.op_count !== 16'd0) begin
      bad++;
      $display("FAIL rm_async got v=%b busy=%b rdy=%b out=%h id=%0d cnt=%0d exp all 0",
               bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_out, bus.rsp_id, bus.op_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drv_rsp_ready = 1'b1;
    step();
    total++; if (obs_grant !== 0) begin bad++; $display("FAIL rm_first_grant got=%0d exp=0", obs_grant); end
    drv_valid[0] = 1'b0;
    for (int t = 0; t < 8; t++) step();
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drv_valid     = '0;
    drv_rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin drv_a[i] = '0; drv_b[i] = '0; drv_op[i] = '0; end
    model_reset();
    test_reset();
    test_single_add();
    test_saturation();
    test_illegal();
    test_backpressure();
    test_round_robin();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand/result width in bits.
REQ-002 Parameter NUM_REQ, default 4, number of requesters (2..8); IDW = $clog2(NUM_REQ).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_a  input  NUM_REQ*DATA_WIDTH  signed operand A; requester i in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_b  input  NUM_REQ*DATA_WIDTH  signed operand B, same slicing.
REQ-009 req_op  input  NUM_REQ*2  opcode; 00 add, 01 sub, 10 mul, 11 illegal.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_id  output  IDW  index of requester owning the result.
REQ-013 rsp_out  output  DATA_WIDTH  signed result.
REQ-014 rsp_c, rsp_n, rsp_v, rsp_z  output  1 each  ALU flags for the result.
REQ-015 rsp_err  output  1  result came from illegal opcode.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 op_count  output  16  completed-operation counter.

Function
REQ-018 The block SHALL instantiate one ALU_Integer (DATA_WIDTH passed through) and be its only driver.
REQ-019 FSM states SHALL be IDLE, EXEC, RESP.
REQ-020 In IDLE, req_ready[g] SHALL be high combinationally only for the granted index g = first i with req_valid[i] set, searching from rr_ptr upward modulo NUM_REQ; all other req_ready bits low; in EXEC/RESP all req_ready low.
REQ-021 On the edge where req_valid[g] & req_ready[g]: latch A, B, op, id=g into operand registers; rr_ptr <= (g+1) mod NUM_REQ; IDLE -> EXEC.
REQ-022 In EXEC the latched operands and opcode SHALL drive the ALU for exactly one cycle; at the end of EXEC Out/C/N/V/Z SHALL be registered into rsp_*; EXEC -> RESP.
REQ-023 Latched opcode 11 SHALL NOT be presented to the ALU (drive 00); rsp_out=0, all flags 0, rsp_err=1.
REQ-024 rsp_valid SHALL be high exactly in RESP; rsp_* SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-025 On rsp_valid & rsp_ready: op_count increments (wraps 16'hFFFF -> 0, no saturation), RESP -> IDLE.
REQ-026 Latency: acceptance edge T -> rsp_valid high in cycle T+2; minimum issue interval 3 cycles.
REQ-027 Arithmetic SHALL be the ALU's: signed two's complement, result saturated to +max/-min with V=1 on overflow; N = result MSB; Z = (result==0).
REQ-028 Requesters SHALL hold req_valid and payload until accepted; a deasserted req_valid in IDLE simply drops out of arbitration without error.
REQ-029 Input changes during EXEC/RESP SHALL NOT affect the in-flight result.
REQ-030 No requests in IDLE: stay IDLE, rr_ptr unchanged.

Reset
REQ-031 While rst_n=0: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_out=0, rsp_id=0, all flags and rsp_err 0, op_count=0, busy=0, req_ready=0.
REQ-032 Reset asserted mid EXEC/RESP SHALL abort the operation; no response issued for it, op_count unchanged from reset value.
REQ-033 First grant after reset SHALL use rr_ptr=0 search order.

Verification
REQ-034 Single add: req 0, A=8'h01, B=8'h01, op 00, rsp_ready=1 -> accept at T, rsp_valid at T+2, rsp_out=8'h02, N=V=Z=0, rsp_id=0, op_count=1.
REQ-035 Saturation: req 1 A=8'h7F B=8'h01 op 00 -> rsp_out=8'h7F, V=1, N=0; then A=8'hC0 B=8'h0A op 10 -> rsp_out=8'h80, V=1, N=1; sub A=8'hFF B=8'hFF -> rsp_out=0, Z=1.
REQ-036 Round-robin: all four req_valid high continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1; each grant one cycle, spacing 3 cycles; never two req_ready bits high.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, busy=1, no req_ready; rsp_ready=1 -> handshake, next grant in IDLE the following cycle.
REQ-038 Illegal op: req 2 op 11, A=8'h05 -> rsp_out=0, flags 0, rsp_err=1, rsp_id=2, op_count increments.
REQ-039 Reset in RESP with rsp_ready=0 -> outputs at reset values immediately (async), no response after release, next grant starts from requester 0.
